// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game controller: state encoding,
// position width, frame-count defaults and small scoring/hit helpers.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int POS_W = 9;
  typedef logic [POS_W-1:0] pos_t;

  localparam int CNT_W = 8;

  localparam int SERVE_FRAMES_DEF = 60;
  localparam int POINT_FRAMES_DEF = 90;
  localparam int WIN_SCORE_DEF    = 9;

  localparam logic [3:0] SCORE_MAX = 4'd9;

  // Scores are single BCD digits and stick at 9 instead of wrapping.
  function automatic logic [3:0] score_inc(input logic [3:0] v);
    if (v >= SCORE_MAX) begin
      return SCORE_MAX;
    end else begin
      return v + 4'd1;
    end
  endfunction

  // Paddle span is evaluated one bit wider so pad+height never wraps.
  function automatic logic paddle_hit(input pos_t ball, input pos_t pad,
                                      input logic [POS_W:0] height);
    logic [POS_W:0] lo_s;
    logic [POS_W:0] hi_s;
    logic [POS_W:0] b_s;
    lo_s = {1'b0, pad};
    hi_s = lo_s + height;
    b_s  = {1'b0, ball};
    return (b_s >= lo_s) && (b_s < hi_s);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_countdown.sv
// Loadable 8-bit frame down-counter shared by the SERVE and POINT phases;
// decrements once per frame tick, stops at zero and flags it.
module frame_countdown
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Load wins over a decrement on the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (tick && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve, play, point judging, scores and game end.
// Optional score limit (OVER state reachable) is enabled by PONG_SCORE_LIMIT_EN.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIDTH        = 256,
  parameter int PADDLE_H     = 16,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF,
  parameter int WIN_SCORE    = WIN_SCORE_DEF
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [8:0] ball_hpos,
  input  logic [8:0] ball_vpos,
  input  logic [8:0] lpad_vpos,
  input  logic [8:0] rpad_vpos,
  output logic       ball_load,
  output logic       ball_run,
  output logic       serve_right,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam pos_t             RIGHT_WALL = POS_W'(WIDTH - 1);
  localparam logic [POS_W:0]   PAD_SPAN   = (POS_W+1)'(PADDLE_H);

  state_t           state_r;
  state_t           state_nxt;
  logic [3:0]       score_l_r;
  logic [3:0]       score_l_nxt;
  logic [3:0]       score_r_r;
  logic [3:0]       score_r_nxt;
  logic             serve_right_r;
  logic             serve_right_nxt;
  logic             ball_load_r;
  logic             load_nxt;
  logic             ball_run_r;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_zero_s;
  logic             left_wall_s;
  logic             right_wall_s;
  logic             left_hit_s;
  logic             right_hit_s;
  logic             win_s;

  frame_countdown u_countdown (
    .clk      (clk),
    .reset    (reset),
    .tick     (frame_tick),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  assign left_wall_s  = (ball_hpos == {POS_W{1'b0}});
  assign right_wall_s = (ball_hpos == RIGHT_WALL);
  assign left_hit_s   = paddle_hit(ball_vpos, lpad_vpos, PAD_SPAN);
  assign right_hit_s  = paddle_hit(ball_vpos, rpad_vpos, PAD_SPAN);

`ifdef PONG_SCORE_LIMIT_EN
  assign win_s = (score_l_r == 4'(WIN_SCORE)) || (score_r_r == 4'(WIN_SCORE));
`else
  assign win_s = 1'b0;
`endif

  // Next-state, score and counter-load decisions, taken only on frame ticks.
  always_comb begin
    state_nxt       = state_r;
    score_l_nxt     = score_l_r;
    score_r_nxt     = score_r_r;
    serve_right_nxt = serve_right_r;
    load_nxt        = 1'b0;
    cnt_load_s      = 1'b0;
    cnt_val_s       = SERVE_LOAD;
    if (frame_tick) begin
      case (state_r)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_nxt   = ST_SERVE;
            score_l_nxt = 4'd0;
            score_r_nxt = 4'd0;
            load_nxt    = 1'b1;
            cnt_load_s  = 1'b1;
            cnt_val_s   = SERVE_LOAD;
          end else begin
            state_nxt = state_r;
          end
        end
        ST_SERVE: begin
          if (cnt_zero_s) begin
            state_nxt = ST_PLAY;
          end else begin
            state_nxt = ST_SERVE;
          end
        end
        ST_PLAY: begin
          // Left wall is judged first so a degenerate playfield stays deterministic.
          if (left_wall_s) begin
            if (left_hit_s) begin
              state_nxt = ST_PLAY;
            end else begin
              score_r_nxt     = score_inc(score_r_r);
              serve_right_nxt = 1'b0;
              state_nxt       = ST_POINT;
              cnt_load_s      = 1'b1;
              cnt_val_s       = POINT_LOAD;
            end
          end else if (right_wall_s) begin
            if (right_hit_s) begin
              state_nxt = ST_PLAY;
            end else begin
              score_l_nxt     = score_inc(score_l_r);
              serve_right_nxt = 1'b1;
              state_nxt       = ST_POINT;
              cnt_load_s      = 1'b1;
              cnt_val_s       = POINT_LOAD;
            end
          end else begin
            state_nxt = ST_PLAY;
          end
        end
        ST_POINT: begin
          if (cnt_zero_s) begin
            if (win_s) begin
              state_nxt = ST_OVER;
            end else begin
              state_nxt  = ST_SERVE;
              load_nxt   = 1'b1;
              cnt_load_s = 1'b1;
              cnt_val_s  = SERVE_LOAD;
            end
          end else begin
            state_nxt = ST_POINT;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // State and registered outputs; ball_load clears on the next clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      score_l_r     <= 4'd0;
      score_r_r     <= 4'd0;
      serve_right_r <= 1'b1;
      ball_load_r   <= 1'b0;
      ball_run_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      score_l_r     <= score_l_nxt;
      score_r_r     <= score_r_nxt;
      serve_right_r <= serve_right_nxt;
      ball_load_r   <= load_nxt;
      ball_run_r    <= (state_nxt == ST_PLAY);
    end
  end

`ifdef PONG_SCORE_LIMIT_EN
  logic game_over_r;

  // OVER flag tracks the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_over_r <= 1'b0;
    end else begin
      game_over_r <= (state_nxt == ST_OVER);
    end
  end

  assign game_over = game_over_r;
`else
  assign game_over = 1'b0;
`endif

  assign ball_load   = ball_load_r;
  assign ball_run    = ball_run_r;
  assign serve_right = serve_right_r;
  assign score_l     = score_l_r;
  assign score_r     = score_r_r;
  assign state       = state_r;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the 8-bit pong design. It sits above the ball datapath: it serves the ball, enables and freezes ball motion, judges paddle hits and misses at the side walls, keeps both scores and declares the end of the game. All decisions are made once per video frame on `frame_tick`; the ball datapath itself stays unaware of game rules.

## Interface
Parameters:
- `WIDTH`, 256: playfield width in pixels; the right wall is at `ball_hpos == WIDTH-1`.
- `PADDLE_H`, 16: paddle height in pixels.
- `SERVE_FRAMES`, 60: frames the ball is held at the serve position before release.
- `POINT_FRAMES`, 90: frames of freeze after a point.
- `WIN_SCORE`, 9: winning score. Used only with `PONG_SCORE_LIMIT_EN`.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `frame_tick`, input, 1: one-cycle strobe per frame, aligned with the ball datapath update.
- `start`, input, 1: level; a start request, sampled on `frame_tick`.
- `ball_hpos`, input, 9: current ball x position.
- `ball_vpos`, input, 9: current ball y position.
- `lpad_vpos`, input, 9: top row of the left paddle.
- `rpad_vpos`, input, 9: top row of the right paddle.
- `ball_load`, output, 1: pulse; reloads the ball datapath to the serve position.
- `ball_run`, output, 1: level; enables ball motion.
- `serve_right`, output, 1: serve direction; 1 means the ball moves toward the right wall.
- `score_l`, output, 4: left player's score, BCD 0..9.
- `score_r`, output, 4: right player's score, BCD 0..9.
- `game_over`, output, 1: level; high while in OVER.
- `state`, output, 3: current FSM state, for debug and display.

## Operation
FSM states: IDLE, SERVE, PLAY, POINT, OVER. All transitions are evaluated only in cycles where `frame_tick` is high.
- IDLE: `ball_run`=0. When `start` is high, clear both scores, pulse `ball_load`, go to SERVE, and load the frame counter with `SERVE_FRAMES-1`.
- SERVE: `ball_run`=0. The counter decrements once per tick; on a tick with counter==0, go to PLAY.
- PLAY: `ball_run`=1.
  - Left wall (`ball_hpos==0`): a hit when `lpad_vpos <= ball_vpos < lpad_vpos+PADDLE_H`. The sum is computed 10 bits wide with no wrap. On a hit, no action; the datapath bounces the ball. On a miss, `score_r`+1, `serve_right`=0, go to POINT.
  - Right wall (`ball_hpos==WIDTH-1`): the same rule with `rpad_vpos`. On a miss, `score_l`+1, `serve_right`=1, go to POINT.
  - If both wall conditions are true at once (degenerate `WIDTH`), the left wall takes priority.
- POINT: `ball_run`=0 and the counter is loaded with `POINT_FRAMES-1`.
  - On a tick with counter==0: go to OVER if the winning condition holds.
  - Otherwise pulse `ball_load`, reload the counter with `SERVE_FRAMES-1`, and go to SERVE.
- OVER: `ball_run`=0 and `game_over`=1. `start` behaves as in IDLE, i.e. it starts a new game.
- `start` is ignored in SERVE, PLAY and POINT.
- Scores saturate at 9 and never wrap.
- Without the macro, the count is capped at 9 and play continues.

## Timing
- Reset values: IDLE, `ball_load`=0, `ball_run`=0, `serve_right`=1, `score_l`=0, `score_r`=0, `game_over`=0, `state`=IDLE, frame counter=0.
- All outputs are registered and change on the clock edge that samples `frame_tick`. Decision latency is 1 cycle.
- `ball_load` is high for exactly one `clk` cycle, on the cycle after the deciding tick.
- The SERVE state lasts exactly `SERVE_FRAMES` ticks; POINT lasts exactly `POINT_FRAMES` ticks.
- `frame_tick` low: state, counter and scores hold.
- `reset` asserted mid-game: immediate return to reset values, regardless of `clk`.

## Configuration
- `PONG_SCORE_LIMIT_EN` defined: the POINT exit goes to OVER when either score == `WIN_SCORE`.
- Undefined: OVER is unreachable, `game_over` is tied to 0, and play continues indefinitely with scores saturated at 9.

## Structure
- Package `pong_pkg` holds:
  - the state encoding (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4);
  - the 9-bit position type width;
  - the default `SERVE_FRAMES`, `POINT_FRAMES` and `WIN_SCORE` constants.
- Sub-module `frame_countdown`: a loadable down-counter, 8 bits wide, that decrements on `frame_tick` and flags zero. It is shared by the SERVE and POINT states.

## Test plan
- Reset low, then high; `start`=1 on the first tick: `ball_load` pulses one cycle, state=SERVE, scores 0/0; after 60 ticks, state=PLAY and `ball_run`=1.
- PLAY with `ball_hpos`=0, `ball_vpos`=40, `lpad_vpos`=30: a hit, state stays PLAY and scores are unchanged. With `lpad_vpos`=60 instead: `score_r`=1, `serve_right`=0, state=POINT, `ball_run`=0.
- Right-wall boundary, `rpad_vpos`=100: `ball_vpos`=115 is a hit; `ball_vpos`=116 gives `score_l`+1.
- After a miss, 90 ticks later `ball_load` pulses and state=SERVE. No transition may occur while `frame_tick` is held low.
- Macro defined with `WIN_SCORE`=2: after two right-wall misses, OVER with `game_over`=1; then `start` gives scores 0/0 and state SERVE. Macro undefined: 12 misses leave `score_l`=9 and state cycles POINT→SERVE.
- Reset asserted during PLAY, away from a clock edge: outputs return to reset values immediately.
